// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if -- bundle of the display-side signals of seg7_scan_mux.
//   seg_in0..3 : upstream 7-seg codes {g..a}, active high, digits 0..3
//   load       : capture strobe into the shadow bank
//   seg        : segment code of the currently lit digit (active high)
//   an         : digit enables, active low, one-hot-low or all high
//   pending    : captured data waiting for the next frame boundary
//   frame      : one-cycle pulse at the start of each scan frame
//   blank      : per-digit blanking, present only with SCAN_BLANK_EN
// master = data source / observer, slave = seg7_scan_mux.
interface seg7_scan_mux_if;
  logic [6:0] seg_in0, seg_in1, seg_in2, seg_in3;
  logic       load;
  logic [6:0] seg;
  logic [3:0] an;
  logic       pending;
  logic       frame;
`ifdef SCAN_BLANK_EN
  logic [3:0] blank;
`endif

  modport master (
`ifdef SCAN_BLANK_EN
    output blank,
`endif
    output seg_in0, seg_in1, seg_in2, seg_in3, load,
    input  seg, an, pending, frame
  );

  modport slave (
`ifdef SCAN_BLANK_EN
    input  blank,
`endif
    input  seg_in0, seg_in1, seg_in2, seg_in3, load,
    output seg, an, pending, frame
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux -- 4-digit multiplexed 7-segment scanner with a double
// buffered digit bank. Loads land in a shadow bank and are promoted to the
// display bank only at a frame boundary (digit 3 -> digit 0), so a frame is
// never torn.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : seg7_scan_mux_if.slave (seg_in0..3, load, seg, an, pending,
//           frame, and blank when SCAN_BLANK_EN is defined)
// Parameter SCAN_DIV (2..65535): cycles each digit stays lit.
// Optional macro SCAN_BLANK_EN: adds bus.blank, live per-digit blanking.
module seg7_scan_mux #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic            clk,
  input  logic            reset,
  seg7_scan_mux_if.slave  bus
);
  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][6:0]  shadow_q, shadow_d;
  logic [3:0][6:0]  disp_q, disp_d;
  logic             pending_q, pending_d;
  logic             wrap30_q;
  logic             frame_q;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             p_wrap;
  logic             f_edge;

  always_comb begin
    p_wrap  = (presc_q == P_LAST);
    presc_d = p_wrap ? '0 : presc_q + 1'b1;
    idx_d   = p_wrap ? idx_q + 2'd1 : idx_q;
    f_edge  = p_wrap && (idx_q == 2'd3);

    shadow_d = bus.load ? {bus.seg_in3, bus.seg_in2, bus.seg_in1, bus.seg_in0}
                        : shadow_q;
    // Promotion uses the shadow as it stood before this edge, so a load on
    // the boundary edge itself waits for the next frame.
    disp_d    = (f_edge && pending_q) ? shadow_q : disp_q;
    pending_d = bus.load ? 1'b1 : (f_edge ? 1'b0 : pending_q);

    // Outputs register the current index, so the visible digit trails idx
    // by one cycle: digit 0 shows from the first edge after reset, and the
    // boundary edge still shows the old digit 3.
    an_d  = ~(4'b0001 << idx_q);
    seg_d = disp_q[idx_q];
`ifdef SCAN_BLANK_EN
    if (bus.blank[idx_q]) begin
      an_d  = 4'b1111;
      seg_d = 7'h00;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      wrap30_q  <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= 7'h00;
      an_q      <= 4'b1111;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      // frame lines up with digit 0 becoming visible, one edge after the
      // boundary; the first frame after reset has no boundary, so no pulse.
      wrap30_q  <= f_edge;
      frame_q   <= wrap30_q;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.pending = pending_q;
  assign bus.frame   = frame_q;
endmodule
